// File: rtl/cnn_session_ctrl_pkg.sv
// cnn_session_ctrl_pkg: shared widths, opcodes, states and LDM swizzle for the session controller
package cnn_session_ctrl_pkg;
  localparam int WORD_BITS = 16;
  localparam int CTX_BITS = 32;
  localparam int PE_NUM_BITS = 4;
  localparam int LDM_NUM_BITS = 2;
  localparam int LDM_ADDR_BITS = 7;
  localparam int WRAM_ADDR_BITS = 14;
  localparam int BRAM_ADDR_BITS = 8;
  localparam int CRAM_ADDR_BITS = 6;
  localparam int CMD_ADDR_BITS = 16;
  localparam int LIN_BITS = PE_NUM_BITS + LDM_ADDR_BITS;
  localparam int LDM_BITS = PE_NUM_BITS + LDM_NUM_BITS + LDM_ADDR_BITS;
  typedef enum logic [2:0] {CMD_WR_LDM, CMD_WR_WRAM, CMD_WR_BRAM, CMD_WR_CRAM, CMD_RUN} cmd_op_e;
  typedef enum logic [2:0] {IDLE, START, WAIT, RD_ISSUE, RD_CAP, DONE} state_e;
  function automatic logic [LDM_BITS-1:0] ldm_swz(input logic [LIN_BITS-1:0] a);
    return {a[PE_NUM_BITS-1:0], {LDM_NUM_BITS{1'b0}}, a[LIN_BITS-1:PE_NUM_BITS]};
  endfunction
endpackage

// File: rtl/cnn_session_ctrl_if.sv
// cnn_session_ctrl_if: host command stream and result stream of the session controller
interface cnn_session_ctrl_if;
  import cnn_session_ctrl_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [CMD_ADDR_BITS-1:0] cmd_addr;
  logic [CTX_BITS-1:0] cmd_data;
  logic res_valid;
  logic res_ready;
  logic [WORD_BITS-1:0] res_data;
  logic res_last;
  modport master(output cmd_valid, cmd_op, cmd_addr, cmd_data, res_ready, input cmd_ready, res_valid, res_data, res_last);
  modport slave(input cmd_valid, cmd_op, cmd_addr, cmd_data, res_ready, output cmd_ready, res_valid, res_data, res_last);
endinterface

// File: rtl/cnn_rd_addr_gen.sv
// cnn_rd_addr_gen: group-strided linear LDM index for result readback, no divider
module cnn_rd_addr_gen
  import cnn_session_ctrl_pkg::*;
#(
  parameter int OUT_COUNT = 1280,
  parameter int GROUP_VALID = 20,
  parameter int GROUP_STRIDE = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  output logic [LIN_BITS-1:0] idx,
  output logic last
);
  localparam int GW = $clog2(GROUP_VALID);
  localparam int CW = $clog2(OUT_COUNT);
  logic [GW-1:0] grp;
  logic [LIN_BITS-1:0] base;
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = grp == GW'(GROUP_VALID - 1);
  assign idx = base + LIN_BITS'(grp);
  assign last = cnt == CW'(OUT_COUNT - 1);
  // grp walks the valid slots of a group; base jumps a stride when grp wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp <= '0;
      base <= '0;
      cnt <= '0;
    end else if (load) begin
      grp <= '0;
      base <= '0;
      cnt <= '0;
    end else if (adv) begin
      grp <= wrap ? '0 : grp + GW'(1);
      base <= wrap ? base + LIN_BITS'(GROUP_STRIDE) : base;
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/cnn_session_ctrl.sv
// cnn_session_ctrl: CNN_1D_Core session sequencer (load, start, wait, readback); CNN_SESSION_WDOG_EN adds a WAIT watchdog
module cnn_session_ctrl
  import cnn_session_ctrl_pkg::*;
#(
  parameter int OUT_COUNT = 1280,
  parameter int GROUP_VALID = 20,
  parameter int GROUP_STRIDE = 32,
  parameter int WDOG_CYCLES = 1 << 20
) (
  input  logic clk,
  input  logic rst_n,
  cnn_session_ctrl_if.slave bus,
  output logic [LDM_BITS-1:0] ldm_addr,
  output logic [WORD_BITS-1:0] ldm_din,
  output logic ldm_en,
  output logic ldm_we,
  input  logic [WORD_BITS-1:0] ldm_dout,
  output logic [WRAM_ADDR_BITS-1:0] wram_addr,
  output logic [WORD_BITS-1:0] wram_din,
  output logic wram_en,
  output logic wram_we,
  output logic [BRAM_ADDR_BITS-1:0] bram_addr,
  output logic [WORD_BITS-1:0] bram_din,
  output logic bram_en,
  output logic bram_we,
  output logic [CRAM_ADDR_BITS-1:0] cram_addr,
  output logic [CTX_BITS-1:0] cram_din,
  output logic cram_en,
  output logic cram_we,
  output logic core_start,
  input  logic core_complete,
  output logic busy,
  output logic session_done,
  output logic session_err
);
  state_e state, state_n;
  logic hs, run, rise, cpl_q, first_q, err_q, wd_to, last, adv;
  logic [3:0] wr_q;
  logic [CMD_ADDR_BITS-1:0] wr_addr_q;
  logic [CTX_BITS-1:0] wr_data_q;
  logic [WORD_BITS-1:0] res_q;
  logic [LIN_BITS-1:0] idx;
  logic unused_ok;
  assign hs = bus.cmd_valid & bus.cmd_ready;
  assign run = hs && bus.cmd_op == CMD_RUN;
  assign rise = core_complete & ~cpl_q;
  assign adv = state == RD_CAP && bus.res_ready;

  cnn_rd_addr_gen #(
    .OUT_COUNT(OUT_COUNT),
    .GROUP_VALID(GROUP_VALID),
    .GROUP_STRIDE(GROUP_STRIDE)
  ) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .load(run),
    .adv(adv),
    .idx(idx),
    .last(last)
  );

  // session state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_n = state;
    bus.cmd_ready = state == IDLE;
    busy = state != IDLE;
    core_start = state == START;
    session_done = state == DONE;
    session_err = err_q;
    bus.res_valid = state == RD_CAP;
    bus.res_last = state == RD_CAP && last;
    bus.res_data = (state == RD_CAP && first_q) ? ldm_dout : res_q;
    ldm_en = wr_q[0] | (state == RD_ISSUE);
    ldm_we = wr_q[0];
    ldm_addr = ldm_swz(state == RD_ISSUE ? idx : wr_addr_q[LIN_BITS-1:0]);
    case (state)
      IDLE: state_n = run ? START : IDLE;
      START: state_n = WAIT;
      WAIT: state_n = wd_to ? DONE : rise ? RD_ISSUE : WAIT;
      RD_ISSUE: state_n = RD_CAP;
      RD_CAP: state_n = !bus.res_ready ? RD_CAP : last ? DONE : RD_ISSUE;
      default: state_n = IDLE;
    endcase
  end

  // one-cycle write strobes one cycle after each write handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_q <= {4{hs}} & {bus.cmd_op == CMD_WR_CRAM, bus.cmd_op == CMD_WR_BRAM,
                         bus.cmd_op == CMD_WR_WRAM, bus.cmd_op == CMD_WR_LDM};
      if (hs) begin
        wr_addr_q <= bus.cmd_addr;
        wr_data_q <= bus.cmd_data;
      end
    end
  end

  assign ldm_din = wr_data_q[WORD_BITS-1:0];
  assign wram_en = wr_q[1];
  assign wram_we = wr_q[1];
  assign wram_addr = wr_addr_q[WRAM_ADDR_BITS-1:0];
  assign wram_din = wr_data_q[WORD_BITS-1:0];
  assign bram_en = wr_q[2];
  assign bram_we = wr_q[2];
  assign bram_addr = wr_addr_q[BRAM_ADDR_BITS-1:0];
  assign bram_din = wr_data_q[WORD_BITS-1:0];
  assign cram_en = wr_q[3];
  assign cram_we = wr_q[3];
  assign cram_addr = wr_addr_q[CRAM_ADDR_BITS-1:0];
  assign cram_din = wr_data_q;

  // completion edge history and result hold register (ldm_dout is shown live on the first RD_CAP cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpl_q <= 1'b0;
      first_q <= 1'b0;
      res_q <= '0;
    end else begin
      cpl_q <= core_complete;
      first_q <= state == RD_ISSUE;
      if (state == RD_CAP && first_q) res_q <= ldm_dout;
    end
  end

`ifdef CNN_SESSION_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  assign wd_to = state == WAIT && wd_cnt == WW'(WDOG_CYCLES - 1);
  // WAIT cycle counter and sticky error, cleared by the next RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      wd_cnt <= state == WAIT ? wd_cnt + WW'(1) : '0;
      err_q <= run ? 1'b0 : wd_to ? 1'b1 : err_q;
    end
  end
  assign unused_ok = ^wr_addr_q[CMD_ADDR_BITS-1:WRAM_ADDR_BITS];
`else
  assign wd_to = 1'b0;
  assign err_q = 1'b0;
  assign unused_ok = ^{wr_addr_q[CMD_ADDR_BITS-1:WRAM_ADDR_BITS], WDOG_CYCLES[0]};
`endif
endmodule

// File: tb/tb_cnn_session_ctrl.sv
// tb_cnn_session_ctrl: directed checks of writes, readback order, backpressure, stale complete, reset and watchdog
module tb_cnn_session_ctrl;
  import cnn_session_ctrl_pkg::*;
  localparam int OC = 1280;
  localparam int GV = 20;
  localparam int GS = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [LDM_BITS-1:0] ldm_addr;
  logic [WORD_BITS-1:0] ldm_din, ldm_dout, wram_din, bram_din;
  logic ldm_en, ldm_we, wram_en, wram_we, bram_en, bram_we, cram_en, cram_we;
  logic [WRAM_ADDR_BITS-1:0] wram_addr;
  logic [BRAM_ADDR_BITS-1:0] bram_addr;
  logic [CRAM_ADDR_BITS-1:0] cram_addr;
  logic [CTX_BITS-1:0] cram_din;
  logic core_start, core_complete, busy, session_done, session_err;
  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int rd0, done0, k, n;
  logic seen_valid;

  cnn_session_ctrl_if bus();

  cnn_session_ctrl #(.OUT_COUNT(OC), .GROUP_VALID(GV), .GROUP_STRIDE(GS), .WDOG_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ldm_addr(ldm_addr), .ldm_din(ldm_din), .ldm_en(ldm_en), .ldm_we(ldm_we), .ldm_dout(ldm_dout),
    .wram_addr(wram_addr), .wram_din(wram_din), .wram_en(wram_en), .wram_we(wram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_en(bram_en), .bram_we(bram_we),
    .cram_addr(cram_addr), .cram_din(cram_din), .cram_en(cram_en), .cram_we(cram_we),
    .core_start(core_start), .core_complete(core_complete), .busy(busy),
    .session_done(session_done), .session_err(session_err)
  );

  always #5 clk = ~clk;

  // LDM model: registered read returning a tag of the physical address
  always @(posedge clk) begin
    if (ldm_en && !ldm_we) ldm_dout <= 16'hA000 | {3'b000, ldm_addr};
    if (ldm_en && !ldm_we) rd_cnt <= rd_cnt + 1;
    if (session_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [15:0] exp_data(input int beat);
    int idx, a;
    idx = (beat / GV) * GS + beat % GV;
    a = (idx % 16) * 512 + idx / 16;
    return 16'hA000 | a[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_run();
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd4;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic readback(input bit stall_en, output int beats);
    int stall;
    logic [15:0] held;
    stall = 0;
    held = '0;
    beats = 0;
    bus.res_ready = 1'b1;
    for (int cyc = 0; cyc < 4000 && beats < OC; cyc++) begin
      step();
      if (bus.res_valid) begin
        if (stall_en && beats == 100 && stall < 5) begin
          bus.res_ready = 1'b0;
          if (stall == 0) held = bus.res_data;
          else chk("hold_data", {16'h0, bus.res_data}, {16'h0, held});
          stall++;
        end else begin
          bus.res_ready = 1'b1;
          chk("res_data", {16'h0, bus.res_data}, {16'h0, exp_data(beats)});
          chk("res_last", {31'h0, bus.res_last}, {31'h0, beats == OC - 1});
          if (beats == 19) chk("map19", {16'h0, bus.res_data}, 32'h0000A601);
          if (beats == 20) chk("map20", {16'h0, bus.res_data}, 32'h0000A002);
          if (beats == 1279) chk("map1279", {16'h0, bus.res_data}, 32'h0000A67F);
          beats++;
        end
      end
    end
    chk("beats", beats, OC);
    step();
    chk("done_pulse", {31'h0, session_done}, 1);
    step();
    chk("done_low", {31'h0, session_done}, 0);
    chk("idle_ready", {31'h0, bus.cmd_ready}, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_addr = '0;
    bus.cmd_data = '0;
    bus.res_ready = 1'b0;
    core_complete = 1'b0;
    #3;
    chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_ldm_en", {31'h0, ldm_en}, 0);
    chk("rst_res_valid", {31'h0, bus.res_valid}, 0);
    chk("rst_start", {31'h0, core_start}, 0);
    chk("rst_err", {31'h0, session_err}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd0;
    bus.cmd_addr = 16'h0025;
    bus.cmd_data = 32'h0000ABCD;
    step();
    bus.cmd_op = 3'd1;
    bus.cmd_addr = 16'd7;
    bus.cmd_data = 32'h00001111;
    chk("ldm_wr_en", {30'h0, ldm_en, ldm_we}, 3);
    chk("ldm_wr_addr", {19'h0, ldm_addr}, 32'hA02);
    chk("ldm_wr_din", {16'h0, ldm_din}, 32'hABCD);
    chk("wram_idle", {31'h0, wram_en}, 0);
    step();
    bus.cmd_op = 3'd2;
    bus.cmd_addr = 16'd3;
    bus.cmd_data = 32'h00002222;
    chk("wram_wr_en", {30'h0, wram_en, wram_we}, 3);
    chk("wram_wr", {wram_addr, wram_din}, {14'd7, 16'h1111});
    chk("ldm_off", {31'h0, ldm_en}, 0);
    step();
    bus.cmd_op = 3'd3;
    bus.cmd_addr = 16'd1;
    bus.cmd_data = 32'h12345678;
    chk("bram_wr_en", {30'h0, bram_en, bram_we}, 3);
    chk("bram_wr", {8'h0, bram_addr, bram_din}, {8'h0, 8'd3, 16'h2222});
    step();
    bus.cmd_op = 3'd6;
    chk("cram_wr_en", {30'h0, cram_en, cram_we}, 3);
    chk("cram_addr", {26'h0, cram_addr}, 1);
    chk("cram_din", cram_din, 32'h12345678);
    chk("bram_off", {31'h0, bram_en}, 0);
    step();
    bus.cmd_valid = 1'b0;
    chk("cram_off", {31'h0, cram_en}, 0);
    step();
    chk("rsvd_noop", {26'h0, ldm_en, wram_en, bram_en, cram_en, busy, bus.cmd_ready}, 1);

    rd0 = rd_cnt;
    done0 = done_cnt;
    send_run();
    chk("start_pulse", {29'h0, core_start, busy, bus.cmd_ready}, 3'b110);
    step();
    chk("start_once", {31'h0, core_start}, 0);
    for (int i = 0; i < 48; i++) step();
    core_complete = 1'b1;
    readback(1'b1, k);
    chk("reads_full", rd_cnt - rd0, OC);
    chk("done_once", done_cnt - done0, 1);
    chk("err_clean", {31'h0, session_err}, 0);

    rd0 = rd_cnt;
    done0 = done_cnt;
    send_run();
    for (int i = 0; i < 10; i++) step();
    core_complete = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("stale_no_read", rd_cnt - rd0, 0);
    chk("stale_busy", {30'h0, busy, bus.res_valid}, 2);
    core_complete = 1'b1;
    readback(1'b0, k);
    chk("stale_reads", rd_cnt - rd0, OC);

    core_complete = 1'b0;
    bus.res_ready = 1'b0;
    send_run();
    for (int i = 0; i < 4; i++) step();
    core_complete = 1'b1;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      step();
      n++;
    end
    chk("reach_rdcap", {31'h0, bus.res_valid}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {24'h0, bus.res_valid, bus.res_last, ldm_en, busy, core_start, session_done, cram_en, bus.cmd_ready}, 1);
    chk("arst_data", {ldm_addr, bus.res_data}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    core_complete = 1'b0;
    step();
    chk("post_rst_ready", {31'h0, bus.cmd_ready}, 1);
    rd0 = rd_cnt;
    done0 = done_cnt;
    send_run();
    for (int i = 0; i < 10; i++) step();
    core_complete = 1'b1;
    readback(1'b0, k);
    chk("clean_reads", rd_cnt - rd0, OC);
    chk("clean_done", done_cnt - done0, 1);

`ifdef CNN_SESSION_WDOG_EN
    core_complete = 1'b0;
    rd0 = rd_cnt;
    send_run();
    n = 1;
    seen_valid = 1'b0;
    while (!session_done && n < 300) begin
      step();
      n++;
      seen_valid = seen_valid | bus.res_valid;
    end
    chk("wdog_cycle", n, 102);
    chk("wdog_err", {31'h0, session_err}, 1);
    chk("wdog_no_beats", {31'h0, seen_valid}, 0);
    chk("wdog_no_reads", rd_cnt - rd0, 0);
    step();
    send_run();
    chk("wdog_err_clear", {31'h0, session_err}, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnn_session_ctrl.md
Name: cnn_session_ctrl

Overview:
- Host-side sequencer for CNN_1D_Core: one inference session = parameter/data load, start, wait for completion, result readback.
- Accepts a command stream and drives the core's AXI_LDM/WRAM/BRAM/CRAM write ports plus start_in.
- After completion it reads OUT_COUNT results from LDM using the group-strided layout and streams them out with valid/ready.

Parameters:
- WORD_BITS, 16, data word width.
- CTX_BITS, 32, CRAM context word width (also cmd_data width).
- PE_NUM_BITS, 4, PE-select bits of the linear LDM index.
- LDM_NUM_BITS, 2, LDM bank bits (always driven 0).
- LDM_ADDR_BITS, 7, per-PE LDM address bits.
- WRAM_ADDR_BITS, 14; BRAM_ADDR_BITS, 8; CRAM_ADDR_BITS, 6.
- OUT_COUNT, 1280, results per session.
- GROUP_VALID, 20, valid results per LDM group.
- GROUP_STRIDE, 32, linear index stride between groups.
- WDOG_CYCLES, 2^20, watchdog limit (optional feature only).

Ports:
- CLK in 1 clock
- RST in 1 asynchronous active-low reset
- cmd_valid in 1; cmd_ready out 1
- cmd_op in 3: 0 WR_LDM, 1 WR_WRAM, 2 WR_BRAM, 3 WR_CRAM, 4 RUN, others reserved
- cmd_addr in 16: linear target address; cmd_data in CTX_BITS
- ldm_addr out PE_NUM_BITS+LDM_NUM_BITS+LDM_ADDR_BITS; ldm_din out WORD_BITS; ldm_en out 1; ldm_we out 1; ldm_dout in WORD_BITS
- wram_addr/wram_din/wram_en/wram_we out; bram_addr/bram_din/bram_en/bram_we out; cram_addr/cram_din/cram_en/cram_we out
- core_start out 1; core_complete in 1
- res_valid out 1; res_ready in 1; res_data out WORD_BITS; res_last out 1
- busy out 1; session_done out 1 (pulse); session_err out 1 (sticky until next RUN)

Behaviour:
- Reset: every output 0 except cmd_ready=1. State IDLE, counters 0. Reset mid-operation aborts the session immediately; no pending write or start is replayed.
- LDM swizzle for both writes and reads, linear index a: ldm_addr = {a[PE_NUM_BITS-1:0], LDM_NUM_BITS'b0, a[PE_NUM_BITS+LDM_ADDR_BITS-1:PE_NUM_BITS]}.
- States: IDLE, START, WAIT, RD_ISSUE, RD_CAP, DONE.
- IDLE:
  - cmd_ready=1.
  - A write op handshake produces a registered en/we pulse of exactly one cycle on the target port, one cycle after the handshake, using cmd_addr (truncated) and cmd_data[WORD_BITS-1:0] (CRAM: full CTX_BITS). Back-to-back commands give one write per cycle.
  - Reserved ops are consumed with no effect.
  - RUN goes to START, clears session_err and counters.
- START: core_start=1 for one cycle, then WAIT. busy=1 in every state except IDLE; cmd_ready=0 in every state except IDLE.
- WAIT:
  - Exits on a rising edge of core_complete (registered previous value). A level that is already high on entry is ignored until it falls and rises again.
  - Rise detected goes to RD_ISSUE.
- Result address generation: counters grp (0..GROUP_VALID-1) and base (+= GROUP_STRIDE on grp wrap). Index = base + grp, so idx 19→19, 20→32, 1279→2035. No divider.
- RD_ISSUE: ldm_en=1, ldm_we=0 for one cycle, then RD_CAP.
- RD_CAP:
  - Capture ldm_dout (1-cycle read latency) into res_data; res_valid=1. res_data and res_last are held stable while res_ready=0.
  - res_last=1 on result OUT_COUNT-1.
  - On handshake: last goes to DONE, else RD_ISSUE.
  - Peak throughput is one result per 2 cycles.
- DONE: session_done=1 for one cycle, then IDLE.

Optional Feature:
- CNN_SESSION_WDOG_EN defined: a cycle counter runs in WAIT. When it reaches WDOG_CYCLES: session_err=1, readback skipped, DONE entered (session_done still pulses).
- Undefined: WAIT has no limit and session_err is tied to 0.

Decomposition:
- Shared package/header (common.vh): opcode constants CMD_WR_LDM..CMD_RUN, state encodings, the LDM swizzle as a function/macro.
- One sub-module: cnn_rd_addr_gen, holding the grp/base counters with load/advance/last outputs.

Test Plan:
- Writes: WR_LDM a=0x25 d=0xABCD, WR_WRAM a=7, WR_BRAM a=3, WR_CRAM a=1 d=0x12345678 back-to-back → four one-cycle en/we pulses in order; LDM address swizzled per the rule above; data exact.
- Full session: RUN, then core_complete rises 50 cycles after core_start → exactly 1280 reads; indices 19/20/1279 map to 19/32/2035; res_last only on the 1280th beat; session_done pulses once.
- Backpressure: hold res_ready=0 for 5 cycles mid-stream → res_data stable, no extra ldm_en, no result lost or duplicated.
- Stale complete: core_complete high at RUN, low 10 cycles later, high 20 cycles after that → readback starts only after the second rise.
- Reset mid-RD_CAP → all outputs 0 asynchronously; cmd_ready=1 after release; a new RUN runs a full clean session.
- Watchdog (CNN_SESSION_WDOG_EN, WDOG_CYCLES=100): core_complete never rises → session_err=1 and session_done at cycle 100 of WAIT, zero res_valid beats.
